mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Executes loads and stores over a single-outstanding req/ack data bus and stalls the pipeline while a transfer is pending.
- Registers the write-back triple (write, addr, data) toward the register file, acting as the MEM/WB register.
- Loads return byte/halfword/word data with sign or zero extension.

Parameters:
- TIMEOUT, 255, max BUSY cycles waiting for bus_ack before abort; 0 = never time out.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- mem_wreg_write  in  1  write-back enable from EX/MEM
- mem_wreg_addr  in  5  destination register
- mem_wreg_data  in  32  ALU result (non-load write data)
- mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- mem_addr  in  32  byte address
- mem_sdata  in  32  store data (low bits used for SB/SH)
- stall_req  out  1  hold EX/MEM and upstream stages (combinational)
- bus_req  out  1  transfer request (registered)
- bus_we  out  1  1 = store
- bus_addr  out  32  {mem_addr[31:2],2'b00}
- bus_be  out  4  byte enables, little-endian lanes
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  load data, valid with bus_ack
- bus_ack  in  1  one-cycle completion strobe
- wb_wreg_write  out  1  registered write-back enable
- wb_wreg_addr  out  5  registered destination register
- wb_wreg_data  out  32  registered write-back data
- bus_err  out  1  one-cycle pulse on timeout abort
- addr_err  out  1  one-cycle pulse on misaligned access (feature only)
- bad_vaddr  out  32  faulting address, valid with addr_err

Behaviour:
- Reset: state IDLE; bus_req, bus_we, bus_err, addr_err, wb_wreg_write = 0; bus_addr, bus_be, bus_wdata, wb_wreg_addr, wb_wreg_data, bad_vaddr, counter = 0. Reset mid-transfer drops bus_req on the next edge; a late bus_ack is ignored.
- States are IDLE, BUSY and DONE.
- IDLE with op NONE:
  - Next edge: wb_* <= mem_wreg_* (1-cycle latency); stall_req = 0.
- IDLE with a load/store op:
  - stall_req = 1.
  - Next edge: register bus_addr, bus_we, bus_be, bus_wdata; set bus_req = 1; clear counter; go BUSY; wb_wreg_write <= 0.
- BUSY:
  - stall_req = 1; bus_req and all bus_* outputs held stable.
  - bus_ack sampled only here. On ack: bus_req <= 0; latch the extended load value (loads); go DONE.
  - No ack: counter increments. If TIMEOUT != 0 and counter == TIMEOUT-1 without ack: bus_req <= 0, bus_err pulses 1 cycle, mark the result suppressed, go DONE.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - stall_req = 0, so the pipeline advances.
  - Next edge: wb_wreg_addr <= mem_wreg_addr.
  - For loads, wb_wreg_data <= latched load value; otherwise wb_wreg_data <= mem_wreg_data.
  - wb_wreg_write <= mem_wreg_write & ~suppressed; go IDLE.
- Byte lane k = mem_addr[1:0].
  - SB: be = 1 << k; wdata = {4{sdata[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{sdata[15:0]}}.
  - SW: be = 1111.
  - Loads: be is the same lane pattern for the access size; bus_we = 0.
- Load extraction: select the byte or halfword from rdata per lane. LB/LH sign-extend; LBU/LHU zero-extend; LW uses the full word.
- Without the feature, misalignment is ignored: addr[0] ignored for H, addr[1:0] ignored for W.
- The block accepts a new op only in IDLE, so at most one transfer is outstanding.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Enabled:
  - A misaligned op (H with addr[0]=1, W with addr[1:0]!=0) is detected in IDLE.
  - Issues no bus request and goes straight to DONE with the result suppressed.
  - addr_err pulses 1 cycle on that edge; bad_vaddr <= mem_addr; stall_req = 1 for that one IDLE cycle.
- Disabled: addr_err and bad_vaddr are tied to 0; behaviour is as in Behaviour.

Test Plan:
- Op NONE, wreg_write=1, addr=3, data=0x1234 -> next cycle wb = (1, 3, 0x00001234); stall_req never asserted.
- LB at 0x1001, ack after 3 cycles with rdata=0x0000_8000 -> bus_be=0010, stall_req high 5 cycles, then wb_wreg_data=0xFFFFFF80; LBU of the same -> 0x00000080.
- SH 0x0000BEEF at 0x2002, immediate ack -> bus_we=1, be=1100, wdata=0xBEEFBEEF; bus_req high exactly 1 cycle; wb_wreg_write follows input (0).
- TIMEOUT=4, LW with no ack -> bus_req high 4 cycles, bus_err pulse, wb_wreg_write=0, returns to IDLE.
- rst asserted during BUSY, then ack arrives -> bus_req 0 after reset edge, ack ignored, all outputs 0.
- MEM_ALIGN_CHECK_EN, LW at 0x3002 -> no bus_req, addr_err pulse, bad_vaddr=0x00003002, wb_wreg_write=0.

Source files
------------

// File: rtl/mem_access.sv
// MEM stage: single-outstanding req/ack load/store engine that also acts as the MEM/WB register.
// Optional misaligned-access trap is compiled in with `define MEM_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | accept op; NONE passes straight to write-back, load/store issues a bus request
// BUSY  | bus_req held, waiting for bus_ack or timeout
// DONE  | transfer finished or aborted; write-back registered, pipeline released
module mem_access #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_wreg_write,
   input  logic [4:0]  mem_wreg_addr,
   input  logic [31:0] mem_wreg_data,
   input  logic [3:0]  mem_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_sdata,
   output logic        stall_req,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        wb_wreg_write,
   output logic [4:0]  wb_wreg_addr,
   output logic [31:0] wb_wreg_data,
   output logic        bus_err,
   output logic        addr_err,
   output logic [31:0] bad_vaddr
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   localparam bit               TO_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT - 1 : 0);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       op_q;
   logic [1:0]       lane_q;
   logic             load_q;
   logic             suppressed;
   logic [31:0]      load_val;

   logic        is_load;
   logic        is_store;
   logic        is_mem;
   logic        size_b;
   logic        size_h;
   logic        size_w;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic        align_fault;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] rd_ext;
   logic        timeout_hit;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      size_b   = 1'b0;
      size_h   = 1'b0;
      size_w   = 1'b0;
      case (mem_op)
         OP_LB, OP_LBU: begin is_load  = 1'b1; size_b = 1'b1; end
         OP_LH, OP_LHU: begin is_load  = 1'b1; size_h = 1'b1; end
         OP_LW:         begin is_load  = 1'b1; size_w = 1'b1; end
         OP_SB:         begin is_store = 1'b1; size_b = 1'b1; end
         OP_SH:         begin is_store = 1'b1; size_h = 1'b1; end
         OP_SW:         begin is_store = 1'b1; size_w = 1'b1; end
         default:       ;
      endcase
      is_mem = is_load | is_store;
   end

   // Lane pattern is shared by loads and stores; store data is replicated across lanes.
   always_comb begin
      be_calc    = 4'b0000;
      wdata_calc = 32'h0;
      if (size_b) begin
         be_calc    = 4'b0001 << mem_addr[1:0];
         wdata_calc = {4{mem_sdata[7:0]}};
      end else if (size_h) begin
         be_calc    = mem_addr[1] ? 4'b1100 : 4'b0011;
         wdata_calc = {2{mem_sdata[15:0]}};
      end else if (size_w) begin
         be_calc    = 4'b1111;
         wdata_calc = mem_sdata;
      end
      if (!is_store) wdata_calc = 32'h0;
   end

`ifdef MEM_ALIGN_CHECK_EN
   assign align_fault = (size_h & mem_addr[0]) | (size_w & (mem_addr[1:0] != 2'b00));
`else
   assign align_fault = 1'b0;
   assign addr_err    = 1'b0;
   assign bad_vaddr   = 32'h0;
`endif

   always_comb begin
      rd_byte = 8'h0;
      case (lane_q)
         2'd0: rd_byte = bus_rdata[7:0];
         2'd1: rd_byte = bus_rdata[15:8];
         2'd2: rd_byte = bus_rdata[23:16];
         2'd3: rd_byte = bus_rdata[31:24];
         default: rd_byte = 8'h0;
      endcase
      rd_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (op_q)
         OP_LB:   rd_ext = {{24{rd_byte[7]}}, rd_byte};
         OP_LBU:  rd_ext = {24'h0, rd_byte};
         OP_LH:   rd_ext = {{16{rd_half[15]}}, rd_half};
         OP_LHU:  rd_ext = {16'h0, rd_half};
         default: rd_ext = bus_rdata;
      endcase
   end

   assign timeout_hit = TO_EN && (cnt == CNT_LAST);

   always_comb begin
      stall_req = 1'b0;
      case (state)
         S_IDLE:  stall_req = is_mem;
         S_BUSY:  stall_req = 1'b1;
         default: stall_req = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         op_q          <= 4'h0;
         lane_q        <= 2'b00;
         load_q        <= 1'b0;
         suppressed    <= 1'b0;
         load_val      <= 32'h0;
         bus_req       <= 1'b0;
         bus_we        <= 1'b0;
         bus_addr      <= 32'h0;
         bus_be        <= 4'h0;
         bus_wdata     <= 32'h0;
         bus_err       <= 1'b0;
         wb_wreg_write <= 1'b0;
         wb_wreg_addr  <= 5'h0;
         wb_wreg_data  <= 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
         addr_err      <= 1'b0;
         bad_vaddr     <= 32'h0;
`endif
      end else begin
         bus_err <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
         addr_err <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (is_mem && align_fault) begin
                  // Misaligned: no bus cycle, finish with the write-back suppressed.
                  op_q          <= mem_op;
                  load_q        <= is_load;
                  suppressed    <= 1'b1;
                  wb_wreg_write <= 1'b0;
                  state         <= S_DONE;
`ifdef MEM_ALIGN_CHECK_EN
                  addr_err      <= 1'b1;
                  bad_vaddr     <= mem_addr;
`endif
               end else if (is_mem) begin
                  bus_req       <= 1'b1;
                  bus_we        <= is_store;
                  bus_addr      <= {mem_addr[31:2], 2'b00};
                  bus_be        <= be_calc;
                  bus_wdata     <= wdata_calc;
                  cnt           <= '0;
                  op_q          <= mem_op;
                  lane_q        <= mem_addr[1:0];
                  load_q        <= is_load;
                  suppressed    <= 1'b0;
                  wb_wreg_write <= 1'b0;
                  state         <= S_BUSY;
               end else begin
                  wb_wreg_write <= mem_wreg_write;
                  wb_wreg_addr  <= mem_wreg_addr;
                  wb_wreg_data  <= mem_wreg_data;
               end
            end
            S_BUSY: begin
               // An ack in the timeout cycle still completes the transfer.
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  if (load_q) load_val <= rd_ext;
                  state   <= S_DONE;
               end else if (timeout_hit) begin
                  bus_req    <= 1'b0;
                  bus_err    <= 1'b1;
                  suppressed <= 1'b1;
                  state      <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               wb_wreg_addr  <= mem_wreg_addr;
               wb_wreg_data  <= load_q ? load_val : mem_wreg_data;
               wb_wreg_write <= mem_wreg_write & ~suppressed;
               state         <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected write-back and bus
// transactions, independent monitors pop and compare them as the DUT produces them.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_wreg_write;
   logic [4:0]  mem_wreg_addr;
   logic [31:0] mem_wreg_data;
   logic [3:0]  mem_op;
   logic [31:0] mem_addr;
   logic [31:0] mem_sdata;
   logic        stall_req;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        wb_wreg_write;
   logic [4:0]  wb_wreg_addr;
   logic [31:0] wb_wreg_data;
   logic        bus_err;
   logic        addr_err;
   logic [31:0] bad_vaddr;

   mem_access #(.TIMEOUT(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .mem_wreg_write(mem_wreg_write), .mem_wreg_addr(mem_wreg_addr),
      .mem_wreg_data(mem_wreg_data), .mem_op(mem_op), .mem_addr(mem_addr),
      .mem_sdata(mem_sdata), .stall_req(stall_req), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack), .wb_wreg_write(wb_wreg_write),
      .wb_wreg_addr(wb_wreg_addr), .wb_wreg_data(wb_wreg_data), .bus_err(bus_err),
      .addr_err(addr_err), .bad_vaddr(bad_vaddr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        w;
      logic [4:0]  a;
      logic [31:0] d;
   } wb_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   wb_t  wb_q[$];
   bus_t bus_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   logic adv_q  = 1'b0;
   logic req_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Write-back monitor: every edge on which the pipeline advanced out of reset yields one result.
   always @(negedge clk) begin
      wb_t e;
      if (adv_q) begin
         if (wb_q.size() == 0) begin
            chk("wb_unexpected", {wb_wreg_write, wb_wreg_addr, 26'h0}, 32'h0);
         end else begin
            e = wb_q.pop_front();
            chk("wb_write", {31'h0, wb_wreg_write}, {31'h0, e.w});
            chk("wb_addr", {27'h0, wb_wreg_addr}, {27'h0, e.a});
            chk("wb_data", wb_wreg_data, e.d);
         end
      end
      #2;
      adv_q = !stall_req && !rst;
   end

   // Bus monitor: each new request is compared against the next expected transaction.
   always @(negedge clk) begin
      bus_t b;
      if (bus_req && !req_prev) begin
         if (bus_q.size() == 0) begin
            chk("bus_unexpected", {31'h0, bus_req}, 32'h0);
         end else begin
            b = bus_q.pop_front();
            chk("bus_we", {31'h0, bus_we}, {31'h0, b.we});
            chk("bus_addr", bus_addr, b.addr);
            chk("bus_be", {28'h0, bus_be}, {28'h0, b.be});
            chk("bus_wdata", bus_wdata, b.wdata);
         end
      end
      req_prev = bus_req;
   end

   // Presents one EX/MEM instruction and holds it until the stage releases the stall.
   task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                         input int ack_after, input logic [31:0] rdata,
                         input logic exp_w, input logic [31:0] exp_d,
                         input int exp_stall, input int exp_req, input int exp_berr,
                         input int exp_aerr, input logic exp_we, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata);
      int   stall_cnt = 0;
      int   req_cnt   = 0;
      int   berr      = 0;
      int   aerr      = 0;
      int   cyc       = 0;
      logic [31:0] bv = 32'h0;
      mem_op         = op;
      mem_addr       = addr;
      mem_sdata      = sdata;
      mem_wreg_write = wr;
      mem_wreg_addr  = wa;
      mem_wreg_data  = wd;
      wb_q.push_back('{w: exp_w, a: wa, d: exp_d});
      if (exp_req > 0) bus_q.push_back('{we: exp_we, addr: {addr[31:2], 2'b00}, be: exp_be, wdata: exp_wdata});
      forever begin
         #1;
         if (bus_err) berr++;
         if (addr_err) begin aerr++; bv = bad_vaddr; end
         bus_ack = 1'b0;
         if (bus_req) begin
            req_cnt++;
            if (req_cnt - 1 == ack_after) begin
               bus_ack   = 1'b1;
               bus_rdata = rdata;
            end
         end
         if (stall_req) stall_cnt++;
         else break;
         cyc++;
         if (cyc > 40) begin
            chk("op_stall_bound", 32'd1, 32'd0);
            break;
         end
         @(posedge clk);
         @(negedge clk);
      end
      bus_ack = 1'b0;
      chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
      chk("req_cycles", 32'(req_cnt), 32'(exp_req));
      chk("bus_err_pulses", 32'(berr), 32'(exp_berr));
      chk("addr_err_pulses", 32'(aerr), 32'(exp_aerr));
      if (exp_aerr > 0) chk("bad_vaddr", bv, addr);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      mem_op = 4'd0; mem_addr = 32'h0; mem_sdata = 32'h0;
      mem_wreg_write = 1'b0; mem_wreg_addr = 5'h0; mem_wreg_data = 32'h0;
      bus_rdata = 32'h0; bus_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
      chk("rst_wb_write", {31'h0, wb_wreg_write}, 32'h0);
      chk("rst_bus_be", {28'h0, bus_be}, 32'h0);
      chk("rst_wb_data", wb_wreg_data, 32'h0);
      chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
      chk("rst_bad_vaddr", bad_vaddr, 32'h0);
      rst = 1'b0;

      //     op     addr          sdata         wr wa  wd            ack rdata         exp_w exp_d        st rq be ae we be       wdata
      run_op(4'd0, 32'h0000_0000, 32'h0,        1, 3,  32'h0000_1234, -1, 32'h0,        1, 32'h0000_1234, 0, 0, 0, 0, 0, 4'b0000, 32'h0);
      run_op(4'd1, 32'h0000_1001, 32'h0,        1, 5,  32'h0000_DEAD,  3, 32'h0000_8000, 1, 32'hFFFF_FF80, 5, 4, 0, 0, 0, 4'b0010, 32'h0);
      run_op(4'd2, 32'h0000_1001, 32'h0,        1, 6,  32'h0000_DEAD,  3, 32'h0000_8000, 1, 32'h0000_0080, 5, 4, 0, 0, 0, 4'b0010, 32'h0);
      run_op(4'd7, 32'h0000_2002, 32'h0000_BEEF, 0, 7, 32'h0000_0055,  0, 32'h0,        0, 32'h0000_0055, 2, 1, 0, 0, 1, 4'b1100, 32'hBEEF_BEEF);
      run_op(4'd5, 32'h0000_4000, 32'h0,        1, 9,  32'h0000_0099, -1, 32'h0,        0, 32'h0000_0080, 5, 4, 1, 0, 0, 4'b1111, 32'h0);
      run_op(4'd3, 32'h0000_1002, 32'h0,        1, 10, 32'h0,          1, 32'h8001_0000, 1, 32'hFFFF_8001, 3, 2, 0, 0, 0, 4'b1100, 32'h0);
      run_op(4'd4, 32'h0000_1000, 32'h0,        1, 11, 32'h0,          0, 32'h0000_F00D, 1, 32'h0000_F00D, 2, 1, 0, 0, 0, 4'b0011, 32'h0);
      run_op(4'd5, 32'h0000_3000, 32'h0,        1, 12, 32'h0,          2, 32'h1234_5678, 1, 32'h1234_5678, 4, 3, 0, 0, 0, 4'b1111, 32'h0);
      run_op(4'd6, 32'h0000_2003, 32'h0000_00A5, 1, 13, 32'h0000_0013, 0, 32'h0,        1, 32'h0000_0013, 2, 1, 0, 0, 1, 4'b1000, 32'hA5A5_A5A5);
      run_op(4'd8, 32'h0000_2000, 32'hCAFE_F00D, 0, 14, 32'h0,         0, 32'h0,        0, 32'h0,         2, 1, 0, 0, 1, 4'b1111, 32'hCAFE_F00D);
`ifdef MEM_ALIGN_CHECK_EN
      run_op(4'd5, 32'h0000_3002, 32'h0,        1, 15, 32'h0,         -1, 32'h0,        0, 32'h1234_5678, 1, 0, 0, 1, 0, 4'b1111, 32'h0);
`else
      run_op(4'd5, 32'h0000_3002, 32'h0,        1, 15, 32'h0,          0, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 2, 1, 0, 0, 0, 4'b1111, 32'h0);
`endif
      run_op(4'd12, 32'h0000_0007, 32'h0,       1, 4,  32'h0000_0077, -1, 32'h0,        1, 32'h0000_0077, 0, 0, 0, 0, 0, 4'b0000, 32'h0);

      // Reset while BUSY, then a late ack that must be ignored.
      mem_op = 4'd5; mem_addr = 32'h0000_5000; mem_sdata = 32'h0;
      mem_wreg_write = 1'b1; mem_wreg_addr = 5'd2; mem_wreg_data = 32'h0;
      bus_q.push_back('{we: 1'b0, addr: 32'h0000_5000, be: 4'b1111, wdata: 32'h0});
      @(posedge clk);
      @(negedge clk);
      chk("busy_bus_req", {31'h0, bus_req}, 32'h1);
      rst = 1'b1;
      mem_op = 4'd0; mem_addr = 32'h0; mem_wreg_write = 1'b0; mem_wreg_addr = 5'h0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_bus_req", {31'h0, bus_req}, 32'h0);
      rst = 1'b0;
      bus_ack = 1'b1;
      bus_rdata = 32'hFFFF_FFFF;
      wb_q.push_back('{w: 1'b0, a: 5'h0, d: 32'h0});
      @(posedge clk);
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      chk("late_ack_bus_req", {31'h0, bus_req}, 32'h0);
      chk("late_ack_stall", {31'h0, stall_req}, 32'h0);
      chk("late_ack_bus_addr", bus_addr, 32'h0);
      chk("late_ack_bus_err", {31'h0, bus_err}, 32'h0);
      chk("late_ack_wb_write", {31'h0, wb_wreg_write}, 32'h0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("wb_queue_empty", 32'(wb_q.size()), 32'h0);
      chk("bus_queue_empty", 32'(bus_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
